mdu: RTL and testbench

Iterative multiply/divide unit that sits beside the ALU in the execute stage. It consumes the same rs/rt operands the ALU receives and produces the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It takes 33 cycles per multiply or divide; control stalls the pipeline on `busy`. MFHI/MFLO read `HI`/`LO` directly.

---
 rtl/mdu.sv | 149 ++++++++++++++
 tb/tb_mdu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative multiply/divide unit producing HI/LO for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// One operand bit per cycle for 32 cycles, then one sign-fixup/commit cycle.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [63:0] acc_reg;
  logic [31:0] opd_reg;
  logic        is_div_reg, neg_q_reg, neg_r_reg, div0_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        op_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // MULT and DIV are the even codes among the arithmetic ops
  assign op_signed = ~MDUOp[0];
  assign mag_a = (op_signed && A[31]) ? -A : A;
  assign mag_b = (op_signed && B[31]) ? -B : B;

  // Shift-add: multiplier sits in acc[31:0], partial product grows in acc[63:32]
  assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opd_reg} : 33'd0);
  assign mul_next = {mul_sum, acc_reg[31:1]};

  // Restoring divide: remainder in acc[63:32], dividend shifts out / quotient shifts in at acc[31:0]
  assign div_shift = {acc_reg[63:32], acc_reg[31]};
  assign div_ge    = div_shift >= {1'b0, opd_reg};
  assign div_rem   = div_ge ? (div_shift[31:0] - opd_reg) : div_shift[31:0];
  assign div_next  = {div_rem, acc_reg[30:0], div_ge};

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fix  = div0_reg ? 32'hFFFF_FFFF : (neg_q_reg ? -acc_reg[31:0] : acc_reg[31:0]);
  assign rem_fix  = neg_r_reg ? -acc_reg[63:32] : acc_reg[63:32];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (MDUOp)
            3'b000, 3'b001: state_next = MUL;
            3'b010, 3'b011: state_next = DIV;
            default:        state_next = IDLE;
          endcase
        end
      end
      MUL, DIV: if (cnt_reg == 5'd31) state_next = FIX;
      FIX:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= 5'd0;
      acc_reg    <= 64'd0;
      opd_reg    <= 32'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (MDUOp)
              3'b000, 3'b001: begin
                acc_reg    <= {32'd0, mag_b};
                opd_reg    <= mag_a;
                cnt_reg    <= 5'd0;
                is_div_reg <= 1'b0;
                neg_q_reg  <= op_signed & (A[31] ^ B[31]);
                neg_r_reg  <= 1'b0;
                div0_reg   <= 1'b0;
              end
              3'b010, 3'b011: begin
                acc_reg    <= {32'd0, mag_a};
                opd_reg    <= mag_b;
                cnt_reg    <= 5'd0;
                is_div_reg <= 1'b1;
                neg_q_reg  <= op_signed & (A[31] ^ B[31]);
                neg_r_reg  <= op_signed & A[31];
                div0_reg   <= (B == 32'd0);
              end
              3'b100:  hi_reg <= A;
              3'b101:  lo_reg <= A;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_reg <= mul_next;
          cnt_reg <= cnt_reg + 5'd1;
        end
        DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg + 5'd1;
        end
        FIX: begin
          if (is_div_reg) begin
            lo_reg <= quo_fix;
            hi_reg <= rem_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: hand-computed HI/LO results plus timing/abort rules.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  mdu dut (
    .clk(clk), .rst(rst), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present an op at a negedge; it is sampled at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  // Called just after the accepting edge. Measures the busy window, checks the
  // commit, optionally injects an MTLO mid-operation or chains a new op in the done cycle.
  task automatic finish(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int inject, input bit chain,
                        input logic [2:0] nop, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] hi0, lo0;
    int  n;
    bit  moved, overlap;
    hi0 = HI; lo0 = LO; n = 0; moved = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (done) overlap = 1;
      if (HI !== hi0 || LO !== lo0) moved = 1;
      if (n == inject) begin
        start = 1'b1; MDUOp = 3'b101; A = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, " busy_cycles"}, n, 33);
    check({name, " done_with_busy"}, {31'd0, overlap}, 0);
    check({name, " hold_hilo"}, {31'd0, moved}, 0);
    check({name, " done"}, {31'd0, done}, 1);
    check({name, " HI"}, HI, exp_hi);
    check({name, " LO"}, LO, exp_lo);
    if (chain) begin
      start = 1'b1; MDUOp = nop; A = na; B = nb;
      @(posedge clk);
      #1;
      start = 1'b0; A = $urandom; B = $urandom;
    end else begin
      @(negedge clk);
      check({name, " done_pulse_end"}, {31'd0, done}, 0);
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b1; MDUOp = 3'b000; A = 32'd5; B = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset HI", HI, 0);
    check("reset LO", LO, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    rst = 1'b0; start = 1'b0;

    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish("multu_max", 32'hFFFFFFFE, 32'h00000001, 0, 0, 0, 0, 0);

    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    finish("mult_-3x7", 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 0, 0, 0);

    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    finish("div_-7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0, 0, 0);

    issue(3'b011, 32'd100, 32'd7);
    finish("divu_100/7", 32'd2, 32'd14, 0, 0, 0, 0, 0);

    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    finish("div_min/-1", 32'h00000000, 32'h80000000, 0, 0, 0, 0, 0);

    issue(3'b011, 32'd7, 32'd0);
    finish("divu_7/0", 32'd7, 32'hFFFFFFFF, 0, 0, 0, 0, 0);

    issue(3'b100, 32'h12345678, 32'd0);
    @(negedge clk);
    check("mthi HI", HI, 32'h12345678);
    check("mthi LO", LO, 32'hFFFFFFFF);
    check("mthi busy", {31'd0, busy}, 0);
    check("mthi done", {31'd0, done}, 0);

    issue(3'b110, 32'hCAFEF00D, 32'd1);
    @(negedge clk);
    check("invalid busy", {31'd0, busy}, 0);
    check("invalid HI", HI, 32'h12345678);
    check("invalid LO", LO, 32'hFFFFFFFF);

    // MTLO attempted in busy cycle 5 must be dropped
    issue(3'b001, 32'd3, 32'd4);
    finish("multu_mtlo_ignored", 32'd0, 32'd12, 5, 1, 3'b000, 32'd6, 32'hFFFFFFFE);
    finish("mult_6x-2_b2b", 32'hFFFFFFFF, 32'hFFFFFFF4, 0, 1, 3'b000, 32'hFFFFFFFB, 32'hFFFFFFFB);
    finish("mult_-5x-5_b2b", 32'd0, 32'd25, 0, 0, 0, 0, 0);

    // Abort a DIVU with reset in busy cycle 10
    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    @(negedge clk);
    check("abort busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 0);
    check("abort HI", HI, 0);
    check("abort LO", LO, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
